det_unit_seq: RTL and testbench

Sequential, parametrised determinant engine for the matrix coprocessor. It replaces the single-width combinational 3x3 determinant with a start/busy/done unit. The unit handles 2x2 and 3x3 matrices of signed W-bit elements and uses one shared multiplier over several cycles. It sits behind the coprocessor instruction decoder, which loads a packed matrix, pulses start, and reads a saturated W-bit result plus an overflow flag.

---
 rtl/det_unit_seq.sv | 108 ++++++++++
 tb/tb_det_unit_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/det_unit_seq.sv
// det_unit_seq: sequential 2x2/3x3 determinant built around a single shared multiplier, with a saturated result and an overflow flag.
module det_unit_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           size3,
  input  logic [9*W-1:0] m,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   det,
  output logic           ovf
);
  localparam logic [1:0] IDLE = 2'd0, MUL1 = 2'd1, MUL2 = 2'd2, DONE = 2'd3;
  localparam int AW = 3*W+3;
  localparam logic signed [AW-1:0] MAXV = {{(2*W+4){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(2*W+4){1'b1}}, {(W-1){1'b0}}};
  logic [1:0] state_q, state_d;
  logic [9*W-1:0] m_q, m_d;
  logic size3_q, size3_d;
  logic [2:0] t_q, t_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [2*W-1:0] p_q, p_d;
  logic [W-1:0] det_q, det_d;
  logic ovf_q, ovf_d, done_q, done_d;
  logic [2:0] k;
  logic [3:0] ix, iy, iz;
  logic signed [W-1:0] a [9];
  logic signed [2*W-1:0] op_a;
  logic signed [W-1:0] op_b;
  logic signed [3*W-1:0] prod;
  logic signed [AW-1:0] prod_x;
  logic neg, last, in_rng;
  always_comb for (int i = 0; i < 9; i++) a[i] = m_q[(8-i)*W +: W];
  // 2x2 reuses the Sarrus slots 0 and 5, whose first two factors are a00*a11 and a01*a10
  assign k = size3_q ? t_q : (t_q == 3'd0 ? 3'd0 : 3'd5);
  assign {ix, iy, iz} = k == 3'd0 ? 12'h048 : k == 3'd1 ? 12'h156 : k == 3'd2 ? 12'h237 :
                        k == 3'd3 ? 12'h246 : k == 3'd4 ? 12'h057 : 12'h138;
  assign neg = k >= 3'd3;
  assign last = t_q == (size3_q ? 3'd5 : 3'd1);
  assign op_a = (state_q == MUL1) ? {{W{a[ix][W-1]}}, a[ix]} : p_q;
  assign op_b = (state_q == MUL1) ? a[iy] : size3_q ? a[iz] : {{(W-1){1'b0}}, 1'b1};
  assign prod = op_a * op_b;
  assign prod_x = {{3{prod[3*W-1]}}, prod};
  assign in_rng = (acc_q <= MAXV) && (acc_q >= MINV);
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    size3_d = size3_q;
    t_d = t_q;
    acc_d = acc_q;
    p_d = p_q;
    det_d = det_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        m_d = m;
        size3_d = size3;
        acc_d = '0;
        t_d = '0;
        state_d = MUL1;
      end
      MUL1: begin
        p_d = prod[2*W-1:0];
        state_d = MUL2;
      end
      MUL2: begin
        acc_d = neg ? acc_q - prod_x : acc_q + prod_x;
        t_d = last ? t_q : t_q + 3'd1;
        state_d = last ? DONE : MUL1;
      end
      default: begin
        ovf_d = !in_rng;
        det_d = in_rng ? acc_q[W-1:0] : acc_q[AW-1] ? MINV[W-1:0] : MAXV[W-1:0];
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      m_q <= '0;
      size3_q <= 1'b0;
      t_q <= '0;
      acc_q <= '0;
      p_q <= '0;
      det_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      size3_q <= size3_d;
      t_q <= t_d;
      acc_q <= acc_d;
      p_q <= p_d;
      det_q <= det_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign det = det_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_det_unit_seq.sv
// tb_det_unit_seq: directed vector table plus handshake, reset and W=16 sequences for det_unit_seq.
module tb_det_unit_seq;
  logic clk = 0, rst = 0, start = 0, size3 = 0;
  logic [71:0] m = '0;
  logic busy, done, ovf;
  logic [7:0] det;
  logic start16 = 0;
  logic [143:0] m16 = '0;
  logic busy16, done16, ovf16;
  logic [15:0] det16;
  int checks = 0, fails = 0;
  typedef struct {
    logic        sz;
    logic [71:0] mat;
    logic [7:0]  edet;
    logic        eovf;
  } vec_t;
  vec_t v [11];
  always #5 clk = ~clk;
  det_unit_seq #(.W(8)) dut (.clk(clk), .rst(rst), .start(start), .size3(size3), .m(m),
    .busy(busy), .done(done), .det(det), .ovf(ovf));
  det_unit_seq #(.W(16)) dut16 (.clk(clk), .rst(rst), .start(start16), .size3(1'b1), .m(m16),
    .busy(busy16), .done(done16), .det(det16), .ovf(ovf16));
  function automatic logic [71:0] mk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {8'(e0), 8'(e1), 8'(e2), 8'(e3), 8'(e4), 8'(e5), 8'(e6), 8'(e7), 8'(e8)};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Starts a job, scrambles inputs while busy, optionally re-pulses start at edge pulse_at.
  task automatic run_job(input logic sz, input logic [71:0] mat, input logic [7:0] edet,
                         input logic eovf, input int pulse_at, input string name);
    int n = 0;
    @(negedge clk);
    start = 1; size3 = sz; m = mat;
    @(posedge clk); #1;
    chk({name, " busy"}, {31'd0, busy}, 1);
    for (int e = 1; e <= 40 && n == 0; e++) begin
      @(negedge clk);
      start = (e == pulse_at); size3 = ~sz; m = ~mat;
      @(posedge clk); #1;
      if (done) n = e;
    end
    chk({name, " latency"}, n, sz ? 13 : 5);
    chk({name, " det"}, {24'd0, det}, {24'd0, edet});
    chk({name, " ovf"}, {31'd0, ovf}, {31'd0, eovf});
    chk({name, " busy at done"}, {31'd0, busy}, 0);
  endtask
  initial begin
    int nd;
    v[0]  = '{1'b1, mk(1, 2, 2, 0, 4, 1, 3, 5, 1), 8'hED, 1'b0};
    v[1]  = '{1'b1, mk(1, 2, 3, 0, 1, 1, 2, 2, 1), 8'hFD, 1'b0};
    v[2]  = '{1'b0, mk(3, 4, 127, 5, 6, 127, 127, 127, 127), 8'hFE, 1'b0};
    v[3]  = '{1'b1, mk(3, 4, 0, 5, 6, 0, 0, 0, 0), 8'h00, 1'b0};
    v[4]  = '{1'b1, mk(127, 0, 0, 0, 127, 0, 0, 0, 127), 8'h7F, 1'b1};
    v[5]  = '{1'b1, mk(-128, 0, 0, 0, -128, 0, 0, 0, -128), 8'h80, 1'b1};
    v[6]  = '{1'b1, mk(8, 0, 0, 0, 8, 0, 0, 0, 2), 8'h7F, 1'b1};
    v[7]  = '{1'b1, mk(4, 0, 0, 0, 4, 0, 0, 0, 7), 8'h70, 1'b0};
    v[8]  = '{1'b0, mk(0, 100, 9, 100, 0, 9, 9, 9, 9), 8'h80, 1'b1};
    v[9]  = '{1'b0, mk(127, 0, 5, 0, 1, 5, 5, 5, 5), 8'h7F, 1'b0};
    v[10] = '{1'b0, mk(-128, 0, 5, 0, 1, 5, 5, 5, 5), 8'h80, 1'b0};
    #1 rst = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i % 2 == 0); m = {8'($urandom), $urandom, $urandom};
      @(posedge clk); #1;
      chk("reset outputs", {21'd0, busy, done, det, ovf}, 0);
    end
    @(negedge clk);
    rst = 0; start = 0;
    @(posedge clk); #1;
    chk("start under rst dropped", {31'd0, busy}, 0);
    for (int i = 0; i < 11; i++) begin
      run_job(v[i].sz, v[i].mat, v[i].edet, v[i].eovf, 0, $sformatf("vec%0d", i));
      repeat (2) @(posedge clk);
    end
    run_job(1'b1, mk(1, 2, 2, 0, 4, 1, 3, 5, 1), 8'hED, 1'b0, 5, "pulse while busy");
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("no queued job", nd, 0);
    run_job(1'b1, mk(1, 2, 3, 0, 1, 1, 2, 2, 1), 8'hFD, 1'b0, 0, "b2b first");
    run_job(1'b1, mk(127, 0, 0, 0, 127, 0, 0, 0, 127), 8'h7F, 1'b1, 0, "b2b second");
    @(negedge clk);
    start16 = 1; m16 = {16'd200, 48'd0, 16'd200, 48'd0, 16'd200};
    @(posedge clk);
    nd = 0;
    for (int e = 1; e <= 40 && nd == 0; e++) begin
      @(negedge clk);
      start16 = 0;
      @(posedge clk); #1;
      if (done16) nd = e;
    end
    chk("w16 latency", nd, 13);
    chk("w16 det", {16'd0, det16}, 32'h7FFF);
    chk("w16 ovf", {31'd0, ovf16}, 1);
    @(negedge clk);
    start = 1; size3 = 1; m = mk(1, 2, 2, 0, 4, 1, 3, 5, 1);
    @(posedge clk);
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      start = 0;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1;
    #1;
    chk("midop reset busy", {31'd0, busy}, 0);
    chk("midop reset det/ovf", {23'd0, det, ovf}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("no done after abort", nd, 0);
    run_job(1'b1, mk(1, 2, 2, 0, 4, 1, 3, 5, 1), 8'hED, 1'b0, 0, "after reset");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
